sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arbiter.sv | 130 +++++++++++++
 tb/tb_sdram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DMA_XFER = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/sdram_arbiter.sv
// SDRAM arbiter: shares one SDRAM adapter port between the CPU window and a DMA engine.
// The CPU has fixed priority unless SDRAM_ARB_FAIRNESS_EN is defined, in which case a
// streak counter hands the port to a waiting DMA after STARVE_LIMIT back-to-back CPU grants.
//
// state    | meaning
// IDLE     | port free, grant decided this cycle
// CPU_XFER | CPU access outstanding at the adapter
// DMA_XFER | DMA access outstanding at the adapter
// DONE     | one cycle after adapter completion (CPU released / DMA acked)
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cpu_cs,
  input  logic                    i_cpu_rwb,
  input  logic [SDRAM_ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]              i_cpu_data,
  output logic                    o_cpu_wait,
  input  logic                    i_dma_req,
  input  logic                    i_dma_rwb,
  input  logic [SDRAM_ADDR_W-1:0] i_dma_addr,
  input  logic [7:0]              i_dma_data,
  output logic                    o_dma_ack,
  output logic [7:0]              o_rd_data,
  output logic                    o_mem_req,
  output logic                    o_mem_rwb,
  output logic [SDRAM_ADDR_W-1:0] o_mem_addr,
  output logic [7:0]              o_mem_wdata,
  input  logic [7:0]              i_mem_data,
  input  logic                    i_mem_done
);

  arb_state_t state, state_nxt;
  owner_t     owner;
  logic       grant_cpu;
  logic       grant_dma;
  logic       dma_first;
  logic       in_xfer;

  assign in_xfer = (state == CPU_XFER) || (state == DMA_XFER);

`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  logic [STREAK_W-1:0] streak;

  assign dma_first = i_dma_req && (streak == STREAK_W'(STARVE_LIMIT));

  // Count CPU grants that bypassed a waiting DMA; reset once DMA is served or stops asking.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_dma || ((state == IDLE) && !i_dma_req)) begin
      streak <= '0;
    end else if (grant_cpu && i_dma_req) begin
      streak <= streak + STREAK_W'(1);
    end
  end
`else
  assign dma_first = 1'b0;
`endif

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    case (state)
      IDLE: begin
        if (dma_first) begin
          grant_dma = 1'b1;
          state_nxt = DMA_XFER;
        end else if (i_cpu_cs) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_XFER;
        end else if (i_dma_req) begin
          grant_dma = 1'b1;
          state_nxt = DMA_XFER;
        end
      end
      CPU_XFER, DMA_XFER: begin
        if (i_mem_done) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, adapter request fields and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      o_mem_req   <= 1'b0;
      o_mem_rwb   <= 1'b1;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_rd_data   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_cpu) begin
        owner       <= OWN_CPU;
        o_mem_req   <= 1'b1;
        o_mem_rwb   <= i_cpu_rwb;
        o_mem_addr  <= i_cpu_addr;
        o_mem_wdata <= i_cpu_data;
      end else if (grant_dma) begin
        owner       <= OWN_DMA;
        o_mem_req   <= 1'b1;
        o_mem_rwb   <= i_dma_rwb;
        o_mem_addr  <= i_dma_addr;
        o_mem_wdata <= i_dma_data;
      end
      if (in_xfer && i_mem_done) begin
        o_mem_req <= 1'b0;
        // A CPU that walked away from its access gets nothing back.
        if (o_mem_rwb && !((owner == OWN_CPU) && !i_cpu_cs)) begin
          o_rd_data <= i_mem_data;
        end
      end
    end
  end

  assign o_dma_ack  = (state == DONE) && (owner == OWN_DMA);
  assign o_cpu_wait = i_cpu_cs && !((state == DONE) && (owner == OWN_CPU));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed transaction table, hand-written corner
// sequences, then randomized traffic against a transaction-lifecycle reference model.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int STARVE = 4;
`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cpu_cs, i_cpu_rwb;
  logic [24:0] i_cpu_addr;
  logic [7:0]  i_cpu_data;
  logic        o_cpu_wait;
  logic        i_dma_req, i_dma_rwb;
  logic [24:0] i_dma_addr;
  logic [7:0]  i_dma_data;
  logic        o_dma_ack;
  logic [7:0]  o_rd_data;
  logic        o_mem_req, o_mem_rwb;
  logic [24:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_data;
  logic        i_mem_done;

  sdram_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_cs(i_cpu_cs), .i_cpu_rwb(i_cpu_rwb), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .o_cpu_wait(o_cpu_wait),
    .i_dma_req(i_dma_req), .i_dma_rwb(i_dma_rwb), .i_dma_addr(i_dma_addr),
    .i_dma_data(i_dma_data), .o_dma_ack(o_dma_ack),
    .o_rd_data(o_rd_data),
    .o_mem_req(o_mem_req), .o_mem_rwb(o_mem_rwb), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_data(i_mem_data), .i_mem_done(i_mem_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;

  // Acks are counted at the edge that ends each cycle, so one DONE cycle counts once.
  always @(posedge clk) if (o_dma_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_cpu_cs = 0; i_cpu_rwb = 1; i_cpu_addr = '0; i_cpu_data = '0;
    i_dma_req = 0; i_dma_rwb = 1; i_dma_addr = '0; i_dma_data = '0;
    i_mem_data = '0; i_mem_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          is_dma;
    bit          rwb;
    logic [24:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mdata;
    int          lat;
    logic [7:0]  exp_rd;
  } vec_t;

  // One complete transfer for a single requester, starting at a negedge with the arbiter idle.
  task automatic run_xfer(input vec_t v);
    int a0;
    a0 = ack_cnt;
    if (v.is_dma) begin
      i_dma_req = 1; i_dma_rwb = v.rwb; i_dma_addr = v.addr; i_dma_data = v.wdata;
    end else begin
      i_cpu_cs = 1; i_cpu_rwb = v.rwb; i_cpu_addr = v.addr; i_cpu_data = v.wdata;
    end
    i_mem_data = ~v.mdata;
    #1 chk("wait_at_req", 32'(o_cpu_wait), 32'(!v.is_dma));
    @(negedge clk);
    chk("req_after_grant", 32'(o_mem_req), 32'd1);
    chk("mem_addr", 32'(o_mem_addr), 32'(v.addr));
    chk("mem_rwb", 32'(o_mem_rwb), 32'(v.rwb));
    chk("mem_wdata", 32'(o_mem_wdata), 32'(v.wdata));
    for (int k = 0; k < v.lat; k++) begin
      chk("wait_in_xfer", 32'(o_cpu_wait), 32'(!v.is_dma));
      @(negedge clk);
      chk("req_stable", 32'(o_mem_req), 32'd1);
      chk("addr_stable", 32'(o_mem_addr), 32'(v.addr));
    end
    i_mem_done = 1; i_mem_data = v.mdata;
    @(negedge clk);
    i_mem_done = 0; i_mem_data = ~v.mdata;
    chk("req_low_done", 32'(o_mem_req), 32'd0);
    chk("rd_data", 32'(o_rd_data), 32'(v.exp_rd));
    chk("ack_in_done", 32'(o_dma_ack), 32'(v.is_dma));
    chk("wait_in_done", 32'(o_cpu_wait), 32'd0);
    i_cpu_cs = 0; i_dma_req = 0;
    @(negedge clk);
    chk("ack_after", 32'(o_dma_ack), 32'd0);
    chk("req_idle", 32'(o_mem_req), 32'd0);
    chk("ack_count", 32'(ack_cnt - a0), 32'(v.is_dma));
  endtask

  vec_t vecs[6];

  // Reference model: lifecycle of the single shared transfer slot.
  bit          m_busy, m_fin, m_dma;
  bit          m_rwb;
  logic [24:0] m_addr;
  logic [7:0]  m_wdata, m_rd;
  int          m_streak;
  int          lat_cnt;

  initial begin
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{0, 1, 25'h0001234, 8'h00, 8'hA5, 3, 8'hA5};
    vecs[1] = '{1, 0, 25'h1FFFFFF, 8'h3C, 8'h77, 2, 8'hA5};
    vecs[2] = '{0, 0, 25'h0000010, 8'h55, 8'hEE, 0, 8'hA5};
    vecs[3] = '{1, 1, 25'h0ABCDEF, 8'h99, 8'h5A, 1, 8'h5A};
    vecs[4] = '{0, 1, 25'h1000000, 8'h12, 8'h00, 4, 8'h00};
    vecs[5] = '{1, 0, 25'h0000000, 8'hFF, 8'h11, 0, 8'h00};

    do_reset();
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_rwb", 32'(o_mem_rwb), 32'd1);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
    chk("rst_rd", 32'(o_rd_data), 32'd0);
    chk("rst_ack", 32'(o_dma_ack), 32'd0);
    chk("rst_wait", 32'(o_cpu_wait), 32'd0);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Simultaneous requests: CPU first, DMA in the IDLE cycle after the CPU's DONE.
    i_cpu_cs = 1; i_cpu_rwb = 1; i_cpu_addr = 25'h0000AAA; i_cpu_data = 8'h01;
    i_dma_req = 1; i_dma_rwb = 0; i_dma_addr = 25'h0000BBB; i_dma_data = 8'h02;
    @(negedge clk);
    chk("sim_cpu_first", 32'(o_mem_addr), 32'h0000AAA);
    chk("sim_no_ack", 32'(o_dma_ack), 32'd0);
    i_mem_done = 1; i_mem_data = 8'hC3;
    @(negedge clk);
    i_mem_done = 0;
    chk("sim_cpu_done_wait", 32'(o_cpu_wait), 32'd0);
    chk("sim_cpu_rd", 32'(o_rd_data), 32'h000000C3);
    i_cpu_cs = 0;
    @(negedge clk);
    chk("sim_idle_gap", 32'(o_mem_req), 32'd0);
    @(negedge clk);
    chk("sim_dma_req", 32'(o_mem_req), 32'd1);
    chk("sim_dma_addr", 32'(o_mem_addr), 32'h0000BBB);
    i_mem_done = 1;
    @(negedge clk);
    i_mem_done = 0;
    chk("sim_dma_ack", 32'(o_dma_ack), 32'd1);
    chk("sim_rd_keep", 32'(o_rd_data), 32'h000000C3);
    i_dma_req = 0;
    @(negedge clk);

    // Reset in DMA_XFER, then a spurious done in IDLE.
    begin
      int a0;
      a0 = ack_cnt;
      i_dma_req = 1; i_dma_rwb = 1; i_dma_addr = 25'h0123456; i_dma_data = 8'h44;
      @(negedge clk);
      chk("rx_req", 32'(o_mem_req), 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0; i_dma_req = 0;
      chk("rx_req_cleared", 32'(o_mem_req), 32'd0);
      chk("rx_rd_cleared", 32'(o_rd_data), 32'd0);
      i_mem_done = 1; i_mem_data = 8'hEE;
      @(negedge clk);
      i_mem_done = 0;
      chk("spur_req", 32'(o_mem_req), 32'd0);
      chk("spur_ack", 32'(o_dma_ack), 32'd0);
      chk("spur_rd", 32'(o_rd_data), 32'd0);
      @(negedge clk);
      chk("spur_ack2", 32'(o_dma_ack), 32'd0);
      chk("rx_ack_total", 32'(ack_cnt - a0), 32'd0);
      run_xfer('{0, 1, 25'h0000777, 8'h00, 8'h6B, 2, 8'h6B});
    end

    // Both requesters held: fixed priority, or 4 CPU then 1 DMA when fairness is built in.
    i_cpu_cs = 1; i_cpu_rwb = 1; i_cpu_addr = 25'h0000111; i_cpu_data = 8'h00;
    i_dma_req = 1; i_dma_rwb = 0; i_dma_addr = 25'h0000222; i_dma_data = 8'h5D;
    for (int g = 0; g < 10; g++) begin
      int t;
      logic [24:0] exp_addr;
      t = 0;
      @(negedge clk);
      while (!o_mem_req && t < 10) begin
        @(negedge clk);
        t++;
      end
      if (t == 10) chk("prio_timeout", 32'(o_mem_req), 32'd1);
      exp_addr = (FAIR && (g % (STARVE + 1) == STARVE)) ? 25'h0000222 : 25'h0000111;
      chk($sformatf("prio_owner_%0d", g), 32'(o_mem_addr), 32'(exp_addr));
      i_mem_done = 1;
      @(negedge clk);
      i_mem_done = 0;
    end
    do_reset();

    // Randomized traffic.
    m_busy = 0; m_fin = 0; m_dma = 0; m_rwb = 1; m_addr = '0; m_wdata = '0; m_rd = '0;
    m_streak = 0; lat_cnt = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit cpu_served, dma_acked, dma_owned, dma_first, mdone;
      @(negedge clk);
      chk("r_req", 32'(o_mem_req), 32'(m_busy));
      chk("r_rwb", 32'(o_mem_rwb), 32'(m_rwb));
      chk("r_addr", 32'(o_mem_addr), 32'(m_addr));
      chk("r_wdata", 32'(o_mem_wdata), 32'(m_wdata));
      chk("r_rd", 32'(o_rd_data), 32'(m_rd));
      chk("r_ack", 32'(o_dma_ack), 32'(m_fin && m_dma));

      cpu_served = m_fin && !m_dma;
      dma_acked  = m_fin && m_dma;
      dma_owned  = (m_busy || m_fin) && m_dma;

      if (!i_cpu_cs || cpu_served) begin
        i_cpu_cs   = ($urandom_range(0, 2) == 0);
        i_cpu_rwb  = 1'($urandom);
        i_cpu_addr = 25'($urandom);
        i_cpu_data = 8'($urandom);
      end
      if (!i_dma_req || dma_acked) begin
        i_dma_req  = ($urandom_range(0, 3) == 0);
        i_dma_rwb  = 1'($urandom);
        i_dma_addr = 25'($urandom);
        i_dma_data = 8'($urandom);
      end else if (!dma_owned && $urandom_range(0, 15) == 0) begin
        i_dma_req = 0;
      end

      if (m_busy) begin
        if (lat_cnt < 0) lat_cnt = $urandom_range(0, 3);
        mdone = (lat_cnt == 0);
        lat_cnt = mdone ? -1 : lat_cnt - 1;
      end else begin
        mdone = ($urandom_range(0, 7) == 0);
      end
      i_mem_done = mdone;
      i_mem_data = 8'($urandom);

      #1 chk("r_wait", 32'(o_cpu_wait), 32'(i_cpu_cs && !cpu_served));

      if (m_fin) begin
        m_fin = 0;
      end else if (m_busy) begin
        if (mdone) begin
          m_busy = 0;
          m_fin  = 1;
          if (m_rwb && !(!m_dma && !i_cpu_cs)) m_rd = i_mem_data;
        end
      end else begin
        dma_first = FAIR && i_dma_req && (m_streak == STARVE);
        if (dma_first || (!i_cpu_cs && i_dma_req)) begin
          m_busy = 1; m_dma = 1;
          m_rwb = i_dma_rwb; m_addr = i_dma_addr; m_wdata = i_dma_data;
          m_streak = 0;
        end else if (i_cpu_cs) begin
          m_busy = 1; m_dma = 0;
          m_rwb = i_cpu_rwb; m_addr = i_cpu_addr; m_wdata = i_cpu_data;
          m_streak = i_dma_req ? m_streak + 1 : 0;
        end else begin
          m_streak = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
